menu_button_ctrl: RTL
=====================

# menu_button_ctrl

Menu input controller between the mouse interface and the menu pixel generator. It turns mouse position and left-button state into registered hover flags, clicks qualified by press-and-release, a one-cycle start request, and the local/remote connect handshake state. The menu pixel generator uses its hover and connect outputs to colour the buttons. The game FSM consumes `start_game` and `connected`.

## Interface
Parameters:
- `START_X0` 240, `START_X1` 400, `START_Y0` 230, `START_Y1` 290: start button rectangle in 640x480 screen coordinates. X0/Y0 are inclusive; X1/Y1 are exclusive.
- `CONN_X0` 240, `CONN_X1` 400, `CONN_Y0` 330, `CONN_Y1` 390: connect button rectangle, same bound rules.
- `TIMEOUT_CYCLES` 500_000_000: cycles an unanswered local connect request is held before it is withdrawn. Legal range is 2 to 2^32-1.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `menu_en` in 1: the menu screen is active.
- `MOUSE_X` in 10: pointer x, synchronous to `clk`.
- `MOUSE_Y` in 10: pointer y, synchronous to `clk`.
- `MOUSE_LEFT` in 1: left button level, synchronous to `clk`.
- `remote_connect_in` in 1: connect request from the peer board. Asynchronous.
- `mouse_on_start_button` out 1: registered hover flag for the start button.
- `mouse_on_connect_button` out 1: registered hover flag for the connect button.
- `send_connect` out 1: local connect request is pending or held.
- `receive_connect` out 1: synchronized `remote_connect_in`.
- `connected` out 1: equals `send_connect & receive_connect`.
- `start_game` out 1: one-cycle start pulse.
- `connect_timeout` out 1: one-cycle pulse when a local request is withdrawn by timeout.

## Operation
- **Hover:** a flag is 1 when X0 ≤ MOUSE_X < X1 and Y0 ≤ MOUSE_Y < Y1 and `menu_en`=1. The rectangles must not overlap. If they do, start takes priority and `mouse_on_connect_button` is 0.
- **Edge detect:** `left_q` holds the previous `MOUSE_LEFT`. A press is `MOUSE_LEFT & ~left_q`; a release is `~MOUSE_LEFT & left_q`.
- **Click FSM states:** IDLE, ARM_START, ARM_CONN, WAIT_REL. Transitions:
  - IDLE: a press with start hover (registered flag) goes to ARM_START. A press with connect hover goes to ARM_CONN. A press with no hover goes to WAIT_REL.
  - ARM_x: if the hover flag for x drops while the button is held, go to WAIT_REL and fire nothing. On a release with the hover flag for x still 1, fire action x and go to IDLE.
  - WAIT_REL: on a release, go to IDLE.
  - `menu_en`=0 forces IDLE in the next cycle and suppresses all actions. A press already held when `menu_en` rises is not a click, because no rising edge is seen.
- **Start action:** `start_game`=1 for exactly one cycle. It fires regardless of connect state.
- **Connect action:**
  - `send_connect`=0: set it to 1.
  - `send_connect`=1 and `connected`=0: clear it (user cancel).
  - `connected`=1: ignore the action.
- **Remote:** `receive_connect` is a 2-FF synchronizer of `remote_connect_in`.
- **Timeout:**
  - A 32-bit counter increments while `send_connect & ~receive_connect`. It clears to 0 otherwise.
  - When the counter equals `TIMEOUT_CYCLES-1`, the next cycle has `send_connect`=0, `connect_timeout`=1 and counter=0.
  - A user cancel in the same cycle as the timeout yields `send_connect`=0 with no `connect_timeout` pulse.
- **Remote drop while connected:** `connected` falls, `send_connect` stays 1, and the timeout counter restarts from 0.
- `menu_en`=0 does not change `send_connect`, `receive_connect` or the timeout counter.

## Timing
- Reset values: all outputs are 0, the FSM is IDLE, `left_q`=0, the counter is 0, and the synchronizer flops are 0.
- Hover flags: 1-cycle latency from MOUSE_X/Y/`menu_en`.
- Click: a release is sampled at edge N. `start_game` is high during cycle N+1 and `send_connect` changes at N+1. Hover is evaluated from the registered flags at edge N.
- `receive_connect`: 2-cycle latency. `connected` is combinational from the two registers, so it adds no further delay.
- Asserting reset mid-operation clears everything immediately, including an armed click and a pending request. The first press after reset release is a new click.

## Test plan
- Move to (300,250), press, hold, release at (300,250) -> `mouse_on_start_button`=1 one cycle after the move; `start_game` is high for exactly 1 cycle, one cycle after the release sample; `send_connect` stays 0.
- Press at (300,250), drag to (100,100), release -> no `start_game`; FSM returns to IDLE; a later press is handled.
- Click at (300,350) and drive `remote_connect_in`=1 -> `send_connect`=1; `receive_connect` rises 2 cycles after the input; `connected`=1; a further connect click leaves `send_connect`=1.
- With `TIMEOUT_CYCLES`=16, click connect and keep `remote_connect_in`=0 -> `send_connect` falls exactly 16 cycles after it rose, with a coincident 1-cycle `connect_timeout`.
- Click connect twice with no remote -> `send_connect` 0→1→0 and no `connect_timeout`.
- Drop `menu_en` while in ARM_START, then release over start -> no `start_game`, hover flags are 0. Assert `rst_n`=0 with `send_connect`=1 -> all outputs are 0 immediately.

Source files
------------

// File: rtl/menu_button_ctrl.sv
// menu_button_ctrl
//   Turns mouse position and left-button level into registered hover flags,
//   press-and-release qualified clicks, a one-cycle start request and the
//   local/remote connect handshake with a timeout on unanswered requests.
//
//   Click FSM states:
//     state     | meaning
//     IDLE      | button up, waiting for a press
//     ARM_START | pressed over start, fires on release while still hovering
//     ARM_CONN  | pressed over connect, fires on release while still hovering
//     WAIT_REL  | press not qualifying as a click, wait for release
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   menu_en                  menu screen active
//   MOUSE_X, MOUSE_Y         pointer position (10 bit, clk-synchronous)
//   MOUSE_LEFT               left button level
//   remote_connect_in        async connect request from peer
//   mouse_on_start_button    registered hover flag, start button
//   mouse_on_connect_button  registered hover flag, connect button
//   send_connect             local connect request pending/held
//   receive_connect          synchronized remote request
//   connected                send_connect & receive_connect
//   start_game               one-cycle start pulse
//   connect_timeout          one-cycle pulse when a request times out
module menu_button_ctrl #(
  parameter logic [9:0]  START_X0       = 10'd240,
  parameter logic [9:0]  START_X1       = 10'd400,
  parameter logic [9:0]  START_Y0       = 10'd230,
  parameter logic [9:0]  START_Y1       = 10'd290,
  parameter logic [9:0]  CONN_X0        = 10'd240,
  parameter logic [9:0]  CONN_X1        = 10'd400,
  parameter logic [9:0]  CONN_Y0        = 10'd330,
  parameter logic [9:0]  CONN_Y1        = 10'd390,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       menu_en,
  input  logic [9:0] MOUSE_X,
  input  logic [9:0] MOUSE_Y,
  input  logic       MOUSE_LEFT,
  input  logic       remote_connect_in,
  output logic       mouse_on_start_button,
  output logic       mouse_on_connect_button,
  output logic       send_connect,
  output logic       receive_connect,
  output logic       connected,
  output logic       start_game,
  output logic       connect_timeout
);

  typedef enum logic [1:0] {IDLE, ARM_START, ARM_CONN, WAIT_REL} state_t;

  state_t      state_q, state_d;
  logic        hov_start_q, hov_start_d;
  logic        hov_conn_q, hov_conn_d;
  logic        left_q, left_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        send_q, send_d;
  logic        start_q, start_d;
  logic        timeout_q, timeout_d;
  logic [31:0] cnt_q, cnt_d;

  logic in_start, in_conn, press, release_evt;
  logic fire_start, fire_conn, counting, at_tc;

  // Hover decode; start wins if the rectangles ever overlap.
  always_comb begin
    in_start = (MOUSE_X >= START_X0) && (MOUSE_X < START_X1) &&
               (MOUSE_Y >= START_Y0) && (MOUSE_Y < START_Y1);
    in_conn  = (MOUSE_X >= CONN_X0) && (MOUSE_X < CONN_X1) &&
               (MOUSE_Y >= CONN_Y0) && (MOUSE_Y < CONN_Y1);
    hov_start_d = menu_en & in_start;
    hov_conn_d  = menu_en & in_conn & ~in_start;
  end

  // left_q tracks the button even with the menu off, so a press held
  // across menu_en rising produces no edge.
  assign left_d      = MOUSE_LEFT;
  assign press       = MOUSE_LEFT & ~left_q;
  assign release_evt = ~MOUSE_LEFT & left_q;

  always_comb begin
    state_d    = state_q;
    fire_start = 1'b0;
    fire_conn  = 1'b0;
    if (!menu_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            if (hov_start_q)     state_d = ARM_START;
            else if (hov_conn_q) state_d = ARM_CONN;
            else                 state_d = WAIT_REL;
          end
        end
        ARM_START: begin
          if (release_evt) begin
            fire_start = hov_start_q;
            state_d    = IDLE;
          end else if (!hov_start_q) begin
            state_d = WAIT_REL;
          end
        end
        ARM_CONN: begin
          if (release_evt) begin
            fire_conn = hov_conn_q;
            state_d   = IDLE;
          end else if (!hov_conn_q) begin
            state_d = WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (release_evt) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sync1_d = remote_connect_in;
  assign sync2_d = sync1_q;

  // Connect request and timeout. A user action takes precedence over the
  // timeout, so a cancel landing on the terminal count gives no pulse.
  always_comb begin
    counting  = send_q & ~sync2_q;
    at_tc     = counting && (cnt_q == (TIMEOUT_CYCLES - 32'd1));
    send_d    = send_q;
    timeout_d = 1'b0;
    start_d   = fire_start;
    if (fire_conn) begin
      if (!send_q)          send_d = 1'b1;
      else if (!connected)  send_d = 1'b0;
    end else if (at_tc) begin
      send_d    = 1'b0;
      timeout_d = 1'b1;
    end
    if (counting && !at_tc) cnt_d = cnt_q + 32'd1;
    else                    cnt_d = 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hov_start_q <= 1'b0;
      hov_conn_q  <= 1'b0;
      left_q      <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      send_q      <= 1'b0;
      start_q     <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      hov_start_q <= hov_start_d;
      hov_conn_q  <= hov_conn_d;
      left_q      <= left_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      send_q      <= send_d;
      start_q     <= start_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mouse_on_start_button   = hov_start_q;
  assign mouse_on_connect_button = hov_conn_q;
  assign send_connect            = send_q;
  assign receive_connect         = sync2_q;
  assign connected               = send_q & sync2_q;
  assign start_game              = start_q;
  assign connect_timeout         = timeout_q;

endmodule
